// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and widths for the sequential ALU.
package alu_pkg;

  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB  = 5'd10;
  localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'd11;
  localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'd12;
  localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'd13;
  localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'd14;
  localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'd15;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'd16;
  localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'd17;
  localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'd18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider on operand magnitudes with sign fix-up.
// The first step is folded into the start edge and the last into done_o, so WIDTH steps span WIDTH-1 edges.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                start_i,
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  output logic                done_o,
  output logic [WIDTH-1:0]    result_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             run_q, is_div_q, neg_q, sel_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, lo_q, dvs_q;

  logic             sa, sb, init_div, init_neg, init_sel;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             src_div;
  logic [WIDTH-1:0] src_acc, src_lo, src_dvs;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_n, lo_n, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (op_i)
      ALU_MULH, ALU_DIV, ALU_REM: begin
        sa = a_i[WIDTH-1];
        sb = b_i[WIDTH-1];
      end
      ALU_MULHSU: sa = a_i[WIDTH-1];
      default: ;
    endcase
    mag_a    = sa ? -a_i : a_i;
    mag_b    = sb ? -b_i : b_i;
    init_div = (op_i >= ALU_DIV);
    // remainder follows the dividend sign; everything else follows sign product
    init_neg = (op_i == ALU_REM) ? sa : (sa ^ sb);
    init_sel = (op_i == ALU_MULH) || (op_i == ALU_MULHSU) || (op_i == ALU_MULHU) ||
               (op_i == ALU_REM)  || (op_i == ALU_REMU);

    src_div = start_i ? init_div : is_div_q;
    src_acc = start_i ? '0 : acc_q;
    src_lo  = start_i ? (init_div ? mag_a : mag_b) : lo_q;
    src_dvs = start_i ? (init_div ? mag_b : mag_a) : dvs_q;

    mul_sum  = {1'b0, src_acc} + (src_lo[0] ? {1'b0, src_dvs} : '0);
    div_sh   = {src_acc, src_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, src_dvs};
    div_ge   = !div_diff[WIDTH];

    if (src_div) begin
      acc_n = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      lo_n  = {src_lo[WIDTH-2:0], div_ge};
    end else begin
      acc_n = mul_sum[WIDTH:1];
      lo_n  = {mul_sum[0], src_lo[WIDTH-1:1]};
    end

    prod     = {acc_n, lo_n};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -lo_n : lo_n;
    r_fix    = neg_q ? -acc_n : acc_n;
    if (is_div_q) result_o = sel_q ? r_fix : q_fix;
    else          result_o = sel_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
  end

  assign done_o = run_q && (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
    end else if (flush) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      is_div_q <= init_div;
      neg_q    <= init_neg;
      sel_q    <= init_sel;
      cnt_q    <= CW'(WIDTH - 1);
      acc_q    <= acc_n;
      lo_q     <= lo_n;
      dvs_q    <= src_dvs;
    end else if (run_q) begin
      acc_q <= acc_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: 1-cycle base ops, iterative RV32M ops behind valid/ready.
// Macro ALU_MULDIV_EN enables opcodes 11-18; otherwise they return illegal_op in one cycle.
//
//  state   | meaning
//  IDLE    | no op in flight, ready for a request
//  MUL     | iterative multiply running
//  DIV     | iterative divide/remainder running
//  DONE    | result valid, held until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] ALUSel,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    alu_out,
  output logic                a_is_zero,
  output logic                illegal_op,
  output logic                busy
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, ill_q, ill_d;
  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] op_res;
  logic             op_ill;

`ifdef ALU_MULDIV_EN
  logic             go_mul, go_div, iter_start, iter_done, b_zero, div_ovf;
  logic [WIDTH-1:0] iter_res;

  assign b_zero  = (in_b == '0);
  assign div_ovf = (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == '1);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .start_i  (iter_start),
    .op_i     (ALUSel),
    .a_i      (in_a),
    .b_i      (in_b),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

  assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
`else
  assign busy = 1'b0;
`endif

  assign shamt     = in_b[SHW-1:0];
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == ST_DONE);
  assign alu_out   = res_q;
  assign a_is_zero = zero_q;
  assign illegal_op = ill_q;

  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
`ifdef ALU_MULDIV_EN
    go_mul = 1'b0;
    go_div = 1'b0;
`endif
    case (ALUSel)
      ALU_ADD:   op_res = in_a + in_b;
      ALU_SUB:   op_res = in_a - in_b;
      ALU_SLL:   op_res = in_a << shamt;
      ALU_SLT:   op_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_SLTU:  op_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      ALU_XOR:   op_res = in_a ^ in_b;
      ALU_SRL:   op_res = in_a >> shamt;
      ALU_SRA:   op_res = $unsigned($signed(in_a) >>> shamt);
      ALU_OR:    op_res = in_a | in_b;
      ALU_AND:   op_res = in_a & in_b;
      ALU_PASSB: op_res = in_b;
`ifdef ALU_MULDIV_EN
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: go_mul = 1'b1;
      // zero divisor and MIN/-1 have fixed answers, so skip the iterative core
      ALU_DIV, ALU_REM: begin
        if (b_zero)       op_res = (ALUSel == ALU_DIV) ? '1 : in_a;
        else if (div_ovf) op_res = (ALUSel == ALU_DIV) ? in_a : '0;
        else              go_div = 1'b1;
      end
      ALU_DIVU, ALU_REMU: begin
        if (b_zero) op_res = (ALUSel == ALU_DIVU) ? '1 : in_a;
        else        go_div = 1'b1;
      end
`endif
      default: op_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
`ifdef ALU_MULDIV_EN
    iter_start = 1'b0;
`endif
    if (flush) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      zero_d  = (in_a == '0);
      ill_d   = op_ill;
      state_d = ST_DONE;
      res_d   = op_res;
`ifdef ALU_MULDIV_EN
      if (go_mul || go_div) begin
        state_d    = go_mul ? ST_MUL : ST_DIV;
        res_d      = res_q;
        iter_start = 1'b1;
      end
`endif
    end else begin
      case (state_q)
`ifdef ALU_MULDIV_EN
        ST_MUL, ST_DIV: begin
          if (iter_done) begin
            state_d = ST_DONE;
            res_d   = iter_res;
          end
        end
`endif
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

endmodule
